// File: rtl/pipa_counter_sequencer.sv
// PIPA pulse sequencer: synchronizes the six accelerometer pulse lines, holds one pending
// count per channel and hands counts to the counter-cycle timing logic as PINC/MINC strobes.
module pipa_counter_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int FIXED_PRIO  = 1
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       PIPAXp,
    input  logic       PIPAXm,
    input  logic       PIPAYp,
    input  logic       PIPAYm,
    input  logic       PIPAZp,
    input  logic       PIPAZm,
    input  logic       PIPSAM,
    input  logic       CTGNT,
    input  logic       FAILCLR,
    output logic       CTREQ,
    output logic [1:0] CTADR,
    output logic       PINC,
    output logic       MINC,
    output logic       PIPAFL,
    output logic [2:0] FLAXIS
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    // Channel bit 2*axis is the plus line, bit 2*axis+1 the minus line.
    logic [5:0]                    pipa_s;
    logic [SYNC_STAGES-1:0][5:0]   sync_r;
    logic [5:0]                    prev_r;
    logic [5:0]                    evt_s;

    logic [2:0] pend_p_r;
    logic [2:0] pend_m_r;
    logic [2:0] pend_p_nxt_s;
    logic [2:0] pend_m_nxt_s;
    logic [2:0] serve_p_s;
    logic [2:0] serve_m_s;
    logic [2:0] ovf_s;
    logic [2:0] has_s;

    state_t     state_r;
    logic [1:0] sel_axis_r;
    logic       sel_plus_r;
    logic [1:0] rr_ptr_r;
    logic [1:0] arb_s;
    logic       cancel_s;

    // First pending axis found in the search order a0, a1, a2.
    function automatic logic [1:0] pick3(input logic [2:0] has,
                                         input logic [1:0] a0,
                                         input logic [1:0] a1,
                                         input logic [1:0] a2);
        if (has[a0]) begin
            return a0;
        end else if (has[a1]) begin
            return a1;
        end else begin
            return a2;
        end
    endfunction

    assign pipa_s = {PIPAZm, PIPAZp, PIPAYm, PIPAYp, PIPAXm, PIPAXp};
    assign evt_s  = sync_r[SYNC_STAGES-1] & ~prev_r & {6{PIPSAM}};
    assign has_s  = pend_p_r | pend_m_r;

    // input synchronizer chain and edge-detect history
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
            prev_r <= 6'b000000;
        end else begin
            if (SYNC_STAGES > 1) begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], pipa_s};
            end else begin
                sync_r <= pipa_s;
            end
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // pending bits of the axis being pulsed are released on the pulse exit edge
    always_comb begin
        serve_p_s = 3'b000;
        serve_m_s = 3'b000;
        if (state_r == ST_PULSE) begin
            if (sel_plus_r) begin
                serve_p_s = 3'b001 << sel_axis_r;
            end else begin
                serve_m_s = 3'b001 << sel_axis_r;
            end
        end else begin
            serve_p_s = 3'b000;
            serve_m_s = 3'b000;
        end
    end

    // per-axis accumulate / cancel / overflow, applied after the service release
    always_comb begin
        pend_p_nxt_s = pend_p_r & ~serve_p_s;
        pend_m_nxt_s = pend_m_r & ~serve_m_s;
        ovf_s        = 3'b000;
        for (int a = 0; a < 3; a++) begin
            case (evt_s[2*a +: 2])
                2'b01: begin
                    if (pend_m_nxt_s[a]) begin
                        pend_m_nxt_s[a] = 1'b0;
                    end else if (pend_p_nxt_s[a]) begin
                        ovf_s[a] = 1'b1;
                    end else begin
                        pend_p_nxt_s[a] = 1'b1;
                    end
                end
                2'b10: begin
                    if (pend_p_nxt_s[a]) begin
                        pend_p_nxt_s[a] = 1'b0;
                    end else if (pend_m_nxt_s[a]) begin
                        ovf_s[a] = 1'b1;
                    end else begin
                        pend_m_nxt_s[a] = 1'b1;
                    end
                end
                default: begin
                    ovf_s[a] = 1'b0;
                end
            endcase
        end
    end

    // pending count storage
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            pend_p_r <= 3'b000;
            pend_m_r <= 3'b000;
        end else begin
            pend_p_r <= pend_p_nxt_s;
            pend_m_r <= pend_m_nxt_s;
        end
    end

    // sticky overflow flags; a new overflow beats a simultaneous clear
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            PIPAFL <= 1'b0;
            FLAXIS <= 3'b000;
        end else begin
            FLAXIS <= (FAILCLR ? 3'b000 : FLAXIS) | ovf_s;
            PIPAFL <= (FAILCLR ? 1'b0 : PIPAFL) | (|ovf_s);
        end
    end

    // axis selection: fixed X>Y>Z, or round-robin starting after the last served axis
    always_comb begin
        arb_s = 2'd0;
        if (FIXED_PRIO != 0) begin
            arb_s = pick3(has_s, 2'd0, 2'd1, 2'd2);
        end else begin
            case (rr_ptr_r)
                2'd0:    arb_s = pick3(has_s, 2'd1, 2'd2, 2'd0);
                2'd1:    arb_s = pick3(has_s, 2'd2, 2'd0, 2'd1);
                default: arb_s = pick3(has_s, 2'd0, 2'd1, 2'd2);
            endcase
        end
    end

    // The request is withdrawn if its count no longer exists after this edge.
    assign cancel_s = sel_plus_r ? ~pend_p_nxt_s[sel_axis_r] : ~pend_m_nxt_s[sel_axis_r];

    // request/grant sequencing with registered strobe outputs
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            sel_axis_r <= 2'd0;
            sel_plus_r <= 1'b0;
            rr_ptr_r   <= 2'd2;
            CTREQ      <= 1'b0;
            CTADR      <= 2'd0;
            PINC       <= 1'b0;
            MINC       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    PINC <= 1'b0;
                    MINC <= 1'b0;
                    if (|has_s) begin
                        state_r    <= ST_REQ;
                        sel_axis_r <= arb_s;
                        sel_plus_r <= pend_p_r[arb_s];
                        CTREQ      <= 1'b1;
                        CTADR      <= arb_s;
                    end
                end
                ST_REQ: begin
                    if (cancel_s) begin
                        state_r <= ST_IDLE;
                        CTREQ   <= 1'b0;
                    end else if (CTGNT) begin
                        state_r <= ST_PULSE;
                        CTREQ   <= 1'b0;
                        PINC    <= sel_plus_r;
                        MINC    <= ~sel_plus_r;
                    end
                end
                ST_PULSE: begin
                    PINC     <= 1'b0;
                    MINC     <= 1'b0;
                    rr_ptr_r <= sel_axis_r;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    CTREQ   <= 1'b0;
                    PINC    <= 1'b0;
                    MINC    <= 1'b0;
                end
            endcase
        end
    end

endmodule
